// File: rtl/cdb_arbiter_if.sv
// Bundle between the result producers and the CDB arbiter.
// The master modport is the producer side. The slave modport is the arbiter.
interface cdb_arbiter_if #(
    parameter int NUM_SRC = 4,
    parameter int ROB_W   = 5,
    parameter int DATA_W  = 32
);
    // Handshake: source i may raise src_ready[i] only while src_full[i] is 0.
    // The result transfers at the rising edge where src_ready[i]=1, src_full[i]=0,
    // rdy_in=1 and clear=0. cdb_ready marks a one-cycle broadcast with no back-pressure.
    logic                      clear;
    logic [NUM_SRC-1:0]        src_ready;
    logic [NUM_SRC*ROB_W-1:0]  src_rob_id;
    logic [NUM_SRC*DATA_W-1:0] src_value;
    logic [NUM_SRC-1:0]        src_full;
    logic                      cdb_ready;
    logic [ROB_W-1:0]          cdb_rob_id;
    logic [DATA_W-1:0]         cdb_value;

    modport master (
        output clear, src_ready, src_rob_id, src_value,
        input  src_full, cdb_ready, cdb_rob_id, cdb_value
    );

    modport slave (
        input  clear, src_ready, src_rob_id, src_value,
        output src_full, cdb_ready, cdb_rob_id, cdb_value
    );
endinterface

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter for the Common Data Bus.
// Each producer has a one-entry holding slot. The arbiter drives one slot per cycle onto a registered broadcast.
module cdb_arbiter #(
    parameter int NUM_SRC = 4,
    parameter int ROB_W   = 5,
    parameter int DATA_W  = 32
) (
    input  logic         clk_in,
    input  logic         rst_in,
    input  logic         rdy_in,
    cdb_arbiter_if.slave bus
);
    localparam int PTR_W = $clog2(NUM_SRC);

    logic [NUM_SRC-1:0] slot_vld;
    logic [ROB_W-1:0]   slot_rob [NUM_SRC];
    logic [DATA_W-1:0]  slot_val [NUM_SRC];
    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   ptr_next;
    logic [PTR_W-1:0]   grant_idx;
    logic               grant_vld;
    logic [NUM_SRC-1:0] grant_oh;
    logic [NUM_SRC-1:0] full;
    logic               advance;
    int                 idx;

    assign advance = rdy_in & ~bus.clear;

    // Pick the first occupied slot at or above the pointer, wrapping at NUM_SRC.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        idx       = 0;
        for (int k = 0; k < NUM_SRC; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_SRC;
            if (!grant_vld && slot_vld[idx]) begin
                grant_vld = 1'b1;
                grant_idx = PTR_W'(idx);
            end
        end
    end

    always_comb begin
        grant_oh = '0;
        if (grant_vld) grant_oh[grant_idx] = 1'b1;
        ptr_next = (int'(grant_idx) == NUM_SRC - 1) ? '0 : grant_idx + 1'b1;
    end

    // A slot that is draining this cycle can accept a new result at the same edge.
    assign full         = slot_vld & ~(grant_oh & {NUM_SRC{advance}});
    assign bus.src_full = full;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            slot_vld       <= '0;
            rr_ptr         <= '0;
            bus.cdb_ready  <= 1'b0;
            bus.cdb_rob_id <= '0;
            bus.cdb_value  <= '0;
            for (int i = 0; i < NUM_SRC; i++) begin
                slot_rob[i] <= '0;
                slot_val[i] <= '0;
            end
        end else if (rdy_in) begin
            if (bus.clear) begin
                slot_vld      <= '0;
                rr_ptr        <= '0;
                bus.cdb_ready <= 1'b0;
            end else begin
                bus.cdb_ready <= grant_vld;
                if (grant_vld) begin
                    bus.cdb_rob_id <= slot_rob[grant_idx];
                    bus.cdb_value  <= slot_val[grant_idx];
                    rr_ptr         <= ptr_next;
                end
                for (int i = 0; i < NUM_SRC; i++) begin
                    if (bus.src_ready[i] && !full[i]) begin
                        slot_vld[i] <= 1'b1;
                        slot_rob[i] <= bus.src_rob_id[i*ROB_W +: ROB_W];
                        slot_val[i] <= bus.src_value[i*DATA_W +: DATA_W];
                    end else if (grant_oh[i]) begin
                        slot_vld[i] <= 1'b0;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: latency, ordering, fairness, flush, freeze and async reset.
module tb_cdb_arbiter;
    localparam int NUM_SRC = 4;
    localparam int ROB_W   = 5;
    localparam int DATA_W  = 32;

    logic clk_in = 1'b0;
    logic rst_in = 1'b1;
    logic rdy_in = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    cdb_arbiter_if #(.NUM_SRC(NUM_SRC), .ROB_W(ROB_W), .DATA_W(DATA_W)) bus ();

    cdb_arbiter #(.NUM_SRC(NUM_SRC), .ROB_W(ROB_W), .DATA_W(DATA_W)) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .rdy_in (rdy_in),
        .bus    (bus)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle();
        bus.clear      = 1'b0;
        bus.src_ready  = '0;
        bus.src_rob_id = '0;
        bus.src_value  = '0;
    endtask

    task automatic set_src(input int i, input logic [ROB_W-1:0] rob, input logic [DATA_W-1:0] val);
        bus.src_ready[i]                  = 1'b1;
        bus.src_rob_id[i*ROB_W +: ROB_W]  = rob;
        bus.src_value[i*DATA_W +: DATA_W] = val;
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rdy_in = 1'b1;
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        rst_in = 1'b1;
        set_src(0, 5'd7, 32'hDEAD_BEEF);
        #1;
        n_checks++; if (bus.cdb_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", bus.cdb_ready); end
        n_checks++; if (bus.cdb_rob_id !== 5'd0) begin n_fail++; $display("FAIL reset_rob: got %0d want 0", bus.cdb_rob_id); end
        n_checks++; if (bus.cdb_value !== 32'd0) begin n_fail++; $display("FAIL reset_value: got %h want 0", bus.cdb_value); end
        n_checks++; if (bus.src_full !== 4'b0000) begin n_fail++; $display("FAIL reset_full: got %b want 0000", bus.src_full); end
        tick();
        idle();
        rst_in = 1'b0;
    endtask

    task automatic test_latency();
        do_reset();
        set_src(0, 5'd3, 32'h1234_5678);
        #1;
        n_checks++; if (bus.src_full !== 4'b0000) begin n_fail++; $display("FAIL lat_full_c1: got %b want 0000", bus.src_full); end
        tick();
        idle();
        #1;
        n_checks++; if (bus.cdb_ready !== 1'b0) begin n_fail++; $display("FAIL lat_ready_c2: got %b want 0", bus.cdb_ready); end
        n_checks++; if (bus.src_full !== 4'b0000) begin n_fail++; $display("FAIL lat_full_c2: got %b want 0000", bus.src_full); end
        tick();
        #1;
        n_checks++; if (bus.cdb_ready !== 1'b1) begin n_fail++; $display("FAIL lat_ready_c3: got %b want 1", bus.cdb_ready); end
        n_checks++; if (bus.cdb_rob_id !== 5'd3) begin n_fail++; $display("FAIL lat_rob_c3: got %0d want 3", bus.cdb_rob_id); end
        n_checks++; if (bus.cdb_value !== 32'h1234_5678) begin n_fail++; $display("FAIL lat_value_c3: got %h want 12345678", bus.cdb_value); end
        tick();
        #1;
        n_checks++; if (bus.cdb_ready !== 1'b0) begin n_fail++; $display("FAIL lat_ready_c4: got %b want 0", bus.cdb_ready); end
        n_checks++; if (bus.cdb_rob_id !== 5'd3) begin n_fail++; $display("FAIL lat_rob_hold: got %0d want 3", bus.cdb_rob_id); end
    endtask

    task automatic test_all_four();
        logic [3:0] exp_full [6] = '{4'b1110, 4'b1100, 4'b1000, 4'b0000, 4'b0000, 4'b0000};
        logic       exp_rdy  [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        int         exp_rob  [6] = '{0, 1, 2, 3, 4, 4};
        do_reset();
        for (int i = 0; i < NUM_SRC; i++) set_src(i, 5'(i + 1), 32'hA000_0000 + 32'(i + 1));
        #1;
        n_checks++; if (bus.src_full !== 4'b0000) begin n_fail++; $display("FAIL all4_full_in: got %b want 0000", bus.src_full); end
        tick();
        idle();
        for (int c = 0; c < 6; c++) begin
            #1;
            n_checks++; if (bus.src_full !== exp_full[c]) begin n_fail++; $display("FAIL all4_full c%0d: got %b want %b", c, bus.src_full, exp_full[c]); end
            n_checks++; if (bus.cdb_ready !== exp_rdy[c]) begin n_fail++; $display("FAIL all4_ready c%0d: got %b want %b", c, bus.cdb_ready, exp_rdy[c]); end
            if (c > 0) begin
                n_checks++; if (bus.cdb_rob_id !== 5'(exp_rob[c])) begin n_fail++; $display("FAIL all4_rob c%0d: got %0d want %0d", c, bus.cdb_rob_id, exp_rob[c]); end
                n_checks++; if (bus.cdb_value !== 32'hA000_0000 + 32'(exp_rob[c])) begin n_fail++; $display("FAIL all4_value c%0d: got %h want %h", c, bus.cdb_value, 32'hA000_0000 + 32'(exp_rob[c])); end
            end
            tick();
        end
    endtask

    task automatic test_no_starve();
        int         s0       [8] = '{-1, -1, 12, -1, -1, -1, -1, -1};
        int         s2       [8] = '{21, 22, 23, 24, 25, -1, -1, -1};
        logic [3:0] exp_full [8] = '{4'b0110, 4'b0100, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        logic       exp_rdy  [8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        int         exp_rob  [8] = '{0, 10, 11, 20, 12, 23, 25, 25};
        do_reset();
        set_src(0, 5'd10, 32'hC0DE_0000 | 32'd10);
        set_src(1, 5'd11, 32'hC0DE_0000 | 32'd11);
        set_src(2, 5'd20, 32'hC0DE_0000 | 32'd20);
        tick();
        for (int c = 0; c < 8; c++) begin
            idle();
            if (s0[c] >= 0) set_src(0, 5'(s0[c]), 32'hC0DE_0000 | 32'(s0[c]));
            if (s2[c] >= 0) set_src(2, 5'(s2[c]), 32'hC0DE_0000 | 32'(s2[c]));
            #1;
            n_checks++; if (bus.src_full !== exp_full[c]) begin n_fail++; $display("FAIL rr_full c%0d: got %b want %b", c, bus.src_full, exp_full[c]); end
            n_checks++; if (bus.cdb_ready !== exp_rdy[c]) begin n_fail++; $display("FAIL rr_ready c%0d: got %b want %b", c, bus.cdb_ready, exp_rdy[c]); end
            if (c > 0) begin
                n_checks++; if (bus.cdb_rob_id !== 5'(exp_rob[c])) begin n_fail++; $display("FAIL rr_rob c%0d: got %0d want %0d", c, bus.cdb_rob_id, exp_rob[c]); end
                n_checks++; if (bus.cdb_value !== (32'hC0DE_0000 | 32'(exp_rob[c]))) begin n_fail++; $display("FAIL rr_value c%0d: got %h want %h", c, bus.cdb_value, 32'hC0DE_0000 | 32'(exp_rob[c])); end
            end
            tick();
        end
        idle();
    endtask

    task automatic test_clear();
        do_reset();
        for (int i = 0; i < 3; i++) set_src(i, 5'(i + 1), 32'hC0DE_0000 | 32'(i + 1));
        tick();
        idle();
        #1;
        n_checks++; if (bus.src_full !== 4'b0110) begin n_fail++; $display("FAIL clr_full_pre: got %b want 0110", bus.src_full); end
        tick();
        bus.clear = 1'b1;
        set_src(3, 5'd9, 32'hC0DE_0009);
        #1;
        n_checks++; if (bus.cdb_ready !== 1'b1 || bus.cdb_rob_id !== 5'd1) begin n_fail++; $display("FAIL clr_bcast_pre: got rdy %b rob %0d want rdy 1 rob 1", bus.cdb_ready, bus.cdb_rob_id); end
        n_checks++; if (bus.src_full !== 4'b0110) begin n_fail++; $display("FAIL clr_full_during: got %b want 0110", bus.src_full); end
        tick();
        idle();
        for (int c = 0; c < 4; c++) begin
            #1;
            n_checks++; if (bus.cdb_ready !== 1'b0) begin n_fail++; $display("FAIL clr_ready c%0d: got %b want 0", c, bus.cdb_ready); end
            n_checks++; if (bus.src_full !== 4'b0000) begin n_fail++; $display("FAIL clr_full c%0d: got %b want 0000", c, bus.src_full); end
            n_checks++; if (bus.cdb_rob_id !== 5'd1) begin n_fail++; $display("FAIL clr_rob_hold c%0d: got %0d want 1", c, bus.cdb_rob_id); end
            tick();
        end
        // A restarted pointer drains source 0 first.
        for (int i = 0; i < NUM_SRC; i++) set_src(i, 5'(i + 5), 32'hC0DE_0000 | 32'(i + 5));
        tick();
        idle();
        tick();
        #1;
        n_checks++; if (bus.cdb_ready !== 1'b1 || bus.cdb_rob_id !== 5'd5) begin n_fail++; $display("FAIL clr_ptr: got rdy %b rob %0d want rdy 1 rob 5", bus.cdb_ready, bus.cdb_rob_id); end
    endtask

    task automatic test_freeze();
        do_reset();
        set_src(1, 5'd7, 32'hC0DE_0007);
        tick();
        idle();
        rdy_in = 1'b0;
        for (int c = 0; c < 5; c++) begin
            set_src(0, 5'd15, 32'hC0DE_000F);
            #1;
            n_checks++; if (bus.src_full !== 4'b0010) begin n_fail++; $display("FAIL frz_full c%0d: got %b want 0010", c, bus.src_full); end
            n_checks++; if (bus.cdb_ready !== 1'b0 || bus.cdb_rob_id !== 5'd0) begin n_fail++; $display("FAIL frz_out c%0d: got rdy %b rob %0d want rdy 0 rob 0", c, bus.cdb_ready, bus.cdb_rob_id); end
            tick();
        end
        idle();
        rdy_in = 1'b1;
        #1;
        n_checks++; if (bus.src_full !== 4'b0000) begin n_fail++; $display("FAIL frz_full_release: got %b want 0000", bus.src_full); end
        tick();
        #1;
        n_checks++; if (bus.cdb_ready !== 1'b1 || bus.cdb_rob_id !== 5'd7 || bus.cdb_value !== 32'hC0DE_0007) begin n_fail++; $display("FAIL frz_bcast: got rdy %b rob %0d val %h want rdy 1 rob 7 val c0de0007", bus.cdb_ready, bus.cdb_rob_id, bus.cdb_value); end
        rdy_in = 1'b0;
        for (int c = 0; c < 2; c++) begin
            tick();
            #1;
            n_checks++; if (bus.cdb_ready !== 1'b1 || bus.cdb_rob_id !== 5'd7) begin n_fail++; $display("FAIL frz_hold_ready c%0d: got rdy %b rob %0d want rdy 1 rob 7", c, bus.cdb_ready, bus.cdb_rob_id); end
        end
        rdy_in = 1'b1;
        tick();
        #1;
        n_checks++; if (bus.cdb_ready !== 1'b0) begin n_fail++; $display("FAIL frz_once: got %b want 0", bus.cdb_ready); end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 3; i++) set_src(i, 5'(i + 1), 32'hC0DE_0000 | 32'(i + 1));
        tick();
        idle();
        tick();
        #1;
        n_checks++; if (bus.cdb_ready !== 1'b1 || bus.cdb_rob_id !== 5'd1) begin n_fail++; $display("FAIL arst_pre: got rdy %b rob %0d want rdy 1 rob 1", bus.cdb_ready, bus.cdb_rob_id); end
        #1;
        rst_in = 1'b1;
        #1;
        n_checks++; if (bus.cdb_ready !== 1'b0) begin n_fail++; $display("FAIL arst_ready: got %b want 0", bus.cdb_ready); end
        n_checks++; if (bus.cdb_rob_id !== 5'd0 || bus.cdb_value !== 32'd0) begin n_fail++; $display("FAIL arst_data: got rob %0d val %h want 0 0", bus.cdb_rob_id, bus.cdb_value); end
        n_checks++; if (bus.src_full !== 4'b0000) begin n_fail++; $display("FAIL arst_full: got %b want 0000", bus.src_full); end
        rst_in = 1'b0;
        tick();
        for (int c = 0; c < 4; c++) begin
            #1;
            n_checks++; if (bus.cdb_ready !== 1'b0 || bus.src_full !== 4'b0000) begin n_fail++; $display("FAIL arst_drop c%0d: got rdy %b full %b want 0 0000", c, bus.cdb_ready, bus.src_full); end
            tick();
        end
    endtask

    initial begin
        idle();
        test_reset();
        test_latency();
        test_all_four();
        test_no_starve();
        test_clear();
        test_freeze();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
